// File: rtl/tx_port_scheduler.sv
// Round-robin packet scheduler: merges NUM_PORTS AXI-Stream sources onto one master with per-port idle gaps.
// Define TX_SCHED_STATS_EN to add per-port packet counters (pkt_count) and their clear input (stats_clr).

module tx_port_scheduler #(
  parameter int NUM_PORTS            = 4,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int GAP_WIDTH            = 16
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_reset,
  input  logic                                        sw_rst,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  input  logic [NUM_PORTS-1:0]                        port_en,
  input  logic [NUM_PORTS*GAP_WIDTH-1:0]              gap_cycles,
  output logic [$clog2(NUM_PORTS)-1:0]                cur_grant,
  output logic                                        busy
`ifdef TX_SCHED_STATS_EN
  ,
  input  logic                                        stats_clr,
  output logic [NUM_PORTS*32-1:0]                     pkt_count
`endif
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        grant_nxt;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        last_grant_nxt;
  logic [GAP_WIDTH-1:0] gap_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic [GW-1:0]        cand [NUM_PORTS];
  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic                 pkt_end;

  // (base + off) mod NUM_PORTS for off in 1..NUM_PORTS, so one subtraction is enough
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(32'(base)) + off;
    if (s >= NUM_PORTS) begin
      s = s - NUM_PORTS;
    end else begin
      s = s;
    end
    return GW'(s);
  endfunction

  // Per-port eligibility and the search order starting after the last grant
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = port_en[i] & s_axis_tvalid[i] & (gap_cnt[i] == {GAP_WIDTH{1'b0}});
      cand[i]     = wrap_idx(last_grant, i + 1);
    end
  end

  // First eligible port in round-robin order wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = {GW{1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!win_found && eligible[cand[k]]) begin
        win_found = 1'b1;
        win_idx   = cand[k];
      end else begin
        win_found = win_found;
      end
    end
  end

  // Combinational data path from the granted slave while sending
  always_comb begin
    m_axis_tdata  = {C_M_AXIS_DATA_WIDTH{1'b0}};
    m_axis_tstrb  = {(C_M_AXIS_DATA_WIDTH/8){1'b0}};
    m_axis_tuser  = {C_M_AXIS_TUSER_WIDTH{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = {NUM_PORTS{1'b0}};
    if (state == SEND) begin
      m_axis_tdata         = s_axis_tdata[grant*DW +: DW];
      m_axis_tstrb         = s_axis_tstrb[grant*SW +: SW];
      m_axis_tuser         = s_axis_tuser[grant*UW +: UW];
      m_axis_tvalid        = s_axis_tvalid[grant];
      m_axis_tlast         = s_axis_tlast[grant];
      s_axis_tready[grant] = m_axis_tready;
    end else begin
      m_axis_tvalid = 1'b0;
    end
  end

  assign pkt_end   = (state == SEND) & m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign cur_grant = grant;

  // Next-state logic; no arbitration happens in the packet-end cycle
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt      = SEND;
          grant_nxt      = win_idx;
          last_grant_nxt = win_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (pkt_end) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and busy registers
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state      <= IDLE;
      grant      <= {GW{1'b0}};
      last_grant <= GW'(NUM_PORTS - 1);
      busy       <= 1'b0;
    end else if (sw_rst) begin
      state      <= IDLE;
      grant      <= {GW{1'b0}};
      last_grant <= GW'(NUM_PORTS - 1);
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      busy       <= (state_nxt == SEND);
    end
  end

  // Gap counters: reload at packet end beats the free-running decrement
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < NUM_PORTS; i++) gap_cnt[i] <= {GAP_WIDTH{1'b0}};
    end else if (sw_rst) begin
      for (int i = 0; i < NUM_PORTS; i++) gap_cnt[i] <= {GAP_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pkt_end && (grant == GW'(i))) begin
          gap_cnt[i] <= gap_cycles[i*GAP_WIDTH +: GAP_WIDTH];
        end else if (gap_cnt[i] != {GAP_WIDTH{1'b0}}) begin
          gap_cnt[i] <= gap_cnt[i] - {{(GAP_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          gap_cnt[i] <= gap_cnt[i];
        end
      end
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic [31:0] pkt_cnt [NUM_PORTS];

  // Per-port packet counters; a clear wins over a coincident increment
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= 32'd0;
    end else if (sw_rst || stats_clr) begin
      for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pkt_end && (grant == GW'(i))) begin
          pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
        end else begin
          pkt_cnt[i] <= pkt_cnt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_count[g*32 +: 32] = pkt_cnt[g];
  end
`endif

endmodule

// File: doc/tx_port_scheduler.md
Name: tx_port_scheduler

Overview:
- Shares one outbound AXI-Stream (toward the rate limiter / MAC) between NUM_PORTS packet sources.
- Arbitration is round-robin at packet boundaries. Each port gets a programmable minimum idle gap after each packet it sends.
- Sits upstream of the per-interface rate limiter in the generator pipeline. Software controls it through an enable mask and per-port gap registers.

Parameters:
- NUM_PORTS, 4, number of slave stream inputs (2..8).
- C_M_AXIS_DATA_WIDTH, 256, master tdata width.
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal master width.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal master width.
- GAP_WIDTH, 16, width of each per-port gap count.

Ports:
- axi_aclk  in  1  sole clock.
- axi_reset  in  1  asynchronous, active-high reset.
- sw_rst  in  1  synchronous soft reset; same effect as reset, applied on the clock edge.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  flattened tdata; port i occupies slice i.
- s_axis_tstrb  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  flattened tstrb.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  flattened tuser.
- s_axis_tvalid  in  NUM_PORTS  per-port tvalid.
- s_axis_tready  out  NUM_PORTS  per-port tready.
- s_axis_tlast  in  NUM_PORTS  per-port tlast.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  selected data.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  selected strobes.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  selected tuser.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  selected tlast.
- port_en  in  NUM_PORTS  per-port eligibility mask.
- gap_cycles  in  NUM_PORTS*GAP_WIDTH  per-port idle cycles enforced after each packet.
- cur_grant  out  log2(NUM_PORTS)  index of the current or last granted port (status).
- busy  out  1  high while in SEND.

Behaviour:
- Reset (axi_reset async, or sw_rst sync) sets:
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1 (so port 0 is searched first), all gap counters=0, busy=0.
  - All m_axis_* outputs=0 and s_axis_tready=0 while in reset and while in IDLE.
- Eligibility: port i is eligible when port_en[i] & s_axis_tvalid[i] & (gap_cnt[i]==0).
- State IDLE:
  - Search ports last_grant+1, +2, ... modulo NUM_PORTS; first eligible port wins.
  - On a win: register grant and last_grant, go to SEND next cycle.
  - If no port is eligible, stay in IDLE.
  - Arbitration latency: 1 cycle. The earliest first beat appears the cycle after tvalid rises.
- State SEND (combinational path, no extra latency):
  - m_axis_{tdata,tstrb,tuser,tlast,tvalid} = slice[grant].
  - s_axis_tready[grant] = m_axis_tready; all other tready bits = 0.
  - busy=1.
- Packet end: a handshake (m_axis_tvalid & m_axis_tready) with tlast=1 does all of the following:
  - Loads gap_cnt[grant] <= gap_cycles[grant].
  - Returns state to IDLE.
  - Makes no arbitration decision in that same cycle, so there is at least 1 idle cycle between packets.
- Gap counters: each nonzero counter decrements by 1 every cycle, independently of state. A gap of 0 leaves the port immediately eligible. The load at packet end takes priority over the decrement.
- Grant lock: a packet is never interrupted.
  - Clearing port_en[grant] mid-packet takes effect only after tlast.
  - Deasserting s_axis_tvalid[grant] mid-packet stalls the output (m_axis_tvalid=0); the grant is held.
- Fairness: with all ports continuously eligible, grants rotate 0,1,2,...,NUM_PORTS-1,0.
- gap_cycles is sampled only at the packet-end load. Changes during a gap do not affect a running count.
- Reset mid-packet: output drops to idle immediately; the partial packet is abandoned. Upstream is responsible for flushing it.
- cur_grant is registered and holds the last grant value while in IDLE.

Optional Feature:
- Macro TX_SCHED_STATS_EN.
- Defined:
  - Adds output pkt_count, NUM_PORTS*32 bits: per-port count of packets sent, incremented on each tlast handshake of the granted port.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Cleared by reset, sw_rst, and a new input stats_clr (1 bit, synchronous). If stats_clr coincides with an increment, the clear wins.
- Undefined: pkt_count and stats_clr ports do not exist; no counter logic is built.

Test Plan:
- All 4 ports enabled, each always valid with 2-beat packets, gaps=0 → output packet order 0,1,2,3,0; exactly 1 idle cycle between packets; tready only ever asserted on the granted port.
- Port 1 only, gap_cycles[1]=5, back-to-back 1-beat packets → tlast handshakes 7 cycles apart (1 end cycle + 5 gap + 1 arbitration).
- port_en=4'b1011 with all ports valid → port 2 is never granted; order 0,1,3,0.
- m_axis_tready held low for 3 cycles mid-packet on port 0 → beats neither lost nor duplicated; grant stays 0; other ports see tready=0.
- axi_reset pulsed in the middle of port 2's packet → m_axis_tvalid=0 the same cycle; after release, the first grant goes to port 0.
- With TX_SCHED_STATS_EN: 10 packets on port 3, then stats_clr asserted in the same cycle as an 11th tlast → pkt_count[3] reads 10, then 0.
